// File: rtl/demux_rr_ctrl.sv
// Round-robin burst scheduler for the 1-to-4 demux: grants BURST beats per enabled channel.
// Optional macro DEMUX_RR_TIMEOUT_EN abandons a burst after 15 consecutive idle input cycles.
module demux_rr_ctrl #(
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ch_en,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       out_valid,
    output logic             sel1,
    output logic             sel2,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    // Handshake: a beat moves on a cycle where in_valid && in_ready; in_ready never looks at in_valid.
    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PICK = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_cur;
    logic [1:0]       r_last;
    logic [CW-1:0]    r_cnt;
    logic [3:0]       r_out_valid;
    logic [WIDTH-1:0] r_out_data;

    logic [1:0]       w_pick;
    logic             w_pick_found;
    logic             w_drain_ok;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_last_beat;
    logic             w_load;
    logic             w_timeout;

    // The output register can take a new beat if empty or emptying this cycle.
    assign w_drain_ok  = (r_out_valid == 4'd0) || out_ready[r_cur];
    assign w_in_ready  = (r_state == XFER) && w_drain_ok && ch_en[r_cur];
    assign w_accept    = in_valid && w_in_ready;
    assign w_last_beat = w_accept && (r_cnt == LAST_CNT);

    // First enabled channel searching cyclically from last+1; last itself is checked last.
    always_comb begin
        w_pick       = 2'(r_last + 2'd1);
        w_pick_found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (!w_pick_found && ch_en[2'(r_last + 2'(i))]) begin
                w_pick       = 2'(r_last + 2'(i));
                w_pick_found = 1'b1;
            end
        end
    end

`ifdef DEMUX_RR_TIMEOUT_EN
    logic [3:0] r_idle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= 4'd0;
        end else if (r_state != XFER || in_valid) begin
            r_idle_cnt <= 4'd0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 4'd1;
        end
    end

    // Fires on the 15th consecutive idle cycle.
    assign w_timeout = (r_state == XFER) && !in_valid && (r_idle_cnt == 4'd14);
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (ch_en != 4'd0) w_state_nxt = PICK;
            end
            PICK: begin
                if (w_drain_ok) begin
                    if (ch_en == 4'd0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = XFER;
                        w_load      = 1'b1;
                    end
                end
            end
            XFER: begin
                if (w_last_beat || !ch_en[r_cur] || w_timeout) w_state_nxt = PICK;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cur   <= 2'd0;
            r_last  <= 2'd3;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_cur  <= w_pick;
                r_last <= w_pick;
                r_cnt  <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // A new beat overrides the drain, giving back-to-back pass-through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 4'd0;
            r_out_data  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 4'b0001 << r_cur;
            r_out_data  <= in_data;
        end else if (out_ready[r_cur]) begin
            r_out_valid <= 4'd0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign sel1      = r_cur[1];
    assign sel2      = r_cur[0];
    assign busy      = (r_state != IDLE) || (r_out_valid != 4'd0);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_demux_rr_ctrl.sv
// Self-checking bench for demux_rr_ctrl: expected {channel,data} pushed per accepted beat, popped on delivery.
module tb_demux_rr_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   ch_en = 4'd0;
    logic [3:0]   out_ready = 4'hF;
    logic [W-1:0] out_data;
    logic [3:0]   out_valid;
    logic         sel1, sel2, busy;
    logic [1:0]   dbg_state;

    logic [W+1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rel_cyc = 0;

    demux_rr_ctrl #(.WIDTH(W), .BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ch_en(ch_en), .out_ready(out_ready),
        .out_data(out_data), .out_valid(out_valid), .sel1(sel1), .sel2(sel2),
        .busy(busy), .dbg_state(dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] enc(input logic [3:0] v);
        case (v)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // scoreboard: a beat is delivered on a cycle where its channel's out_ready is high
    always @(negedge clk) begin
        if (rst_n && (out_valid & out_ready) != 4'd0) begin
            check("onehot", 32'($onehot(out_valid)), 32'd1);
            check("sel", 32'({sel1, sel2}), 32'(enc(out_valid)));
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'd1, 32'd0);
            end else begin
                check("beat", 32'({enc(out_valid), out_data}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic do_reset(input logic [3:0] en);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 4'hF;
        ch_en     = en;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_sel", 32'({sel1, sel2}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n   = 1'b1;
        rel_cyc = cyc;
    endtask

    // drives one beat and holds it until accepted; in_valid stays high afterwards
    task automatic send_beat(input logic [W-1:0] d, input logic [1:0] ch, output int acc);
        int n;
        n        = 0;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_wait", 32'd0, 32'd1);
            acc = -1;
        end else begin
            exp_q.push_back({ch, d});
            acc = cyc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    int acc[16];
    int a;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        // reset and first grant, burst switch timing
        do_reset(4'hF);
        for (int i = 0; i < 8; i++) send_beat(W'(i + 1), (i < 4) ? 2'd0 : 2'd1, acc[i]);
        check("first_grant_lat", 32'(acc[0] - rel_cyc), 32'd2);
        for (int i = 1; i < 8; i++)
            check("beat_gap", 32'(acc[i] - acc[i-1]), (i == 4) ? 32'd2 : 32'd1);
        check("busy_run", 32'(busy), 32'd1);
        in_valid = 1'b0;
        wait_drain();

        // skip disabled channels
        do_reset(4'b1010);
        for (int i = 0; i < 12; i++)
            send_beat(W'($urandom_range(0, 255)), (i >= 4 && i < 8) ? 2'd3 : 2'd1, a);
        in_valid = 1'b0;
        wait_drain();

        // backpressure on channel 0 after the 2nd beat
        do_reset(4'hF);
        send_beat(8'h11, 2'd0, a);
        send_beat(8'h12, 2'd0, a);
        out_ready = 4'b1110;
        in_data   = 8'h13;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold_data", 32'(out_data), 32'h12);
            check("bp_hold_valid", 32'(out_valid), 32'h1);
        end
        @(posedge clk);
        #1;
        out_ready = 4'hF;
        send_beat(8'h13, 2'd0, a);
        send_beat(8'h14, 2'd0, acc[0]);
        send_beat(8'h15, 2'd1, acc[1]);
        check("bp_switch_gap", 32'(acc[1] - acc[0]), 32'd2);
        in_valid = 1'b0;
        wait_drain();

        // mid-burst disable of channel 0
        do_reset(4'hF);
        send_beat(8'h21, 2'd0, a);
        send_beat(8'h22, 2'd0, acc[0]);
        ch_en   = 4'b1110;
        in_data = 8'h23;
        @(negedge clk);
        check("dis_in_ready", 32'(in_ready), 32'd0);
        send_beat(8'h23, 2'd1, acc[1]);
        check("dis_regrant_lat", 32'(acc[1] - acc[0]), 32'd3);
        in_valid = 1'b0;
        wait_drain();

        // asynchronous reset mid-burst; in-flight beat is lost
        do_reset(4'hF);
        send_beat(8'h31, 2'd0, a);
        send_beat(8'h32, 2'd0, a);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        check("arst_state", 32'(dbg_state), 32'd0);
        exp_q.delete();
        do_reset(4'hF);
        send_beat(8'h33, 2'd0, acc[0]);
        check("arst_regrant_lat", 32'(acc[0] - rel_cyc), 32'd2);
        in_valid = 1'b0;
        wait_drain();

        // idle input after the first beat on channel 0
        do_reset(4'hF);
        send_beat(8'h41, 2'd0, a);
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
`ifdef DEMUX_RR_TIMEOUT_EN
        check("to_sel", 32'({sel1, sel2}), 32'd1);
        for (int i = 0; i < 4; i++) send_beat(W'(8'h42 + i), 2'd1, a);
`else
        check("to_sel", 32'({sel1, sel2}), 32'd0);
        for (int i = 0; i < 4; i++) send_beat(W'(8'h42 + i), (i < 3) ? 2'd0 : 2'd1, a);
`endif
        in_valid = 1'b0;
        wait_drain();

        // all channels disabled: back to IDLE, not busy
        ch_en = 4'd0;
        repeat (4) @(posedge clk);
        #1;
        check("idle_state", 32'(dbg_state), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
